// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file access controller.
package regfile_pkg;

   localparam int unsigned REG_COUNT    = 16;
   localparam int unsigned ADDR_W       = 4;
   localparam int unsigned DATA_W       = 32;
   localparam int unsigned STARVE_W     = 8;
   localparam int unsigned STARVE_LIMIT = 8;

   localparam logic [DATA_W-1:0] INIT_VALUE = '0;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD,
      WR_WAIT,
      RSP
   } state_e;

   // Latched debug request payload.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } dbg_req_t;

endpackage

// File: rtl/regfile_write_mux.sv
// Priority select (init > WB > debug) for the register file's single write port.
module regfile_write_mux
   import regfile_pkg::*;
(
   input  logic              init_en_i,
   input  logic [ADDR_W-1:0] init_idx_i,
   input  logic [DATA_W-1:0] init_val_i,
   input  logic              wb_en_i,
   input  logic [ADDR_W-1:0] wb_dest_i,
   input  logic [DATA_W-1:0] wb_value_i,
   input  logic              dbg_en_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_data_i,
   output logic              we_o,
   output logic [ADDR_W-1:0] dest_o,
   output logic [DATA_W-1:0] wdata_o
);

   always_comb begin
      we_o    = 1'b0;
      dest_o  = wb_dest_i;
      wdata_o = wb_value_i;
      if (init_en_i) begin
         we_o    = 1'b1;
         dest_o  = init_idx_i;
         wdata_o = init_val_i;
      end else if (wb_en_i) begin
         we_o    = 1'b1;
      end else if (dbg_en_i) begin
         we_o    = 1'b1;
         dest_o  = dbg_addr_i;
         wdata_o = dbg_data_i;
      end
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Init sweep, write-port arbitration and debug access sequencing for the 16x32 register file.
module regfile_access_ctrl
   import regfile_pkg::*;
#(
   parameter int unsigned       STARVE_LIMIT_CFG = STARVE_LIMIT,
   parameter logic [DATA_W-1:0] INIT_VALUE_CFG   = INIT_VALUE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en_in,
   input  logic [ADDR_W-1:0] wb_dest_in,
   input  logic [DATA_W-1:0] wb_value_in,
   input  logic              dbg_req_valid,
   output logic              dbg_req_ready,
   input  logic              dbg_req_write,
   input  logic [ADDR_W-1:0] dbg_req_addr,
   input  logic [DATA_W-1:0] dbg_req_wdata,
   output logic              dbg_rsp_valid,
   input  logic              dbg_rsp_ready,
   output logic [DATA_W-1:0] dbg_rsp_rdata,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_dest,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [ADDR_W-1:0] rf_dbg_src,
   input  logic [DATA_W-1:0] rf_dbg_rdata,
   output logic              init_busy,
   output logic              stall_req
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   dbg_req_t            req_q, req_d;
   logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                stall_q, stall_d;
   logic                ready_q, ready_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                busy_q, busy_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= INIT;
         idx_q       <= '0;
         req_q       <= '0;
         rsp_data_q  <= '0;
         starve_q    <= '0;
         stall_q     <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         req_q       <= req_d;
         rsp_data_q  <= rsp_data_d;
         starve_q    <= starve_d;
         stall_q     <= stall_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      req_d      = req_q;
      rsp_data_d = rsp_data_q;
      starve_d   = starve_q;
      stall_d    = stall_q;
      unique case (state_q)
         INIT: begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q == ADDR_W'(REG_COUNT - 1)) begin
               idx_d   = '0;
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (dbg_req_valid && ready_q) begin
               req_d.addr = dbg_req_addr;
               req_d.data = dbg_req_wdata;
               state_d    = dbg_req_write ? WR_WAIT : RD;
            end
         end
         RD: begin
            rsp_data_d = rf_dbg_rdata;
            state_d    = RSP;
         end
         WR_WAIT: begin
            // WB owns the port whenever it writes; the counter tracks how long we've been locked out.
            if (!wb_en_in) begin
               rsp_data_d = req_q.data;
               starve_d   = '0;
               stall_d    = 1'b0;
               state_d    = RSP;
            end else begin
               if (starve_q < STARVE_W'(STARVE_LIMIT_CFG)) begin
                  starve_d = starve_q + STARVE_W'(1);
               end
               if (starve_d >= STARVE_W'(STARVE_LIMIT_CFG)) begin
                  stall_d = 1'b1;
               end
            end
         end
         RSP: begin
            if (dbg_rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = INIT;
      endcase
      ready_d     = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
      busy_d      = (state_d == INIT);
   end

   regfile_write_mux u_write_mux (
      .init_en_i  (state_q == INIT),
      .init_idx_i (idx_q),
      .init_val_i (INIT_VALUE_CFG),
      .wb_en_i    (wb_en_in),
      .wb_dest_i  (wb_dest_in),
      .wb_value_i (wb_value_in),
      .dbg_en_i   (state_q == WR_WAIT),
      .dbg_addr_i (req_q.addr),
      .dbg_data_i (req_q.data),
      .we_o       (rf_we),
      .dest_o     (rf_dest),
      .wdata_o    (rf_wdata)
   );

   assign rf_dbg_src    = req_q.addr;
   assign dbg_req_ready = ready_q;
   assign dbg_rsp_valid = rsp_valid_q;
   assign dbg_rsp_rdata = rsp_data_q;
   assign init_busy     = busy_q;
   assign stall_req     = stall_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a negedge-commit register file model.
module tb_regfile_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_en_in;
   logic [3:0]  wb_dest_in;
   logic [31:0] wb_value_in;
   logic        dbg_req_valid;
   logic        dbg_req_ready;
   logic        dbg_req_write;
   logic [3:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata;
   logic        dbg_rsp_valid;
   logic        dbg_rsp_ready;
   logic [31:0] dbg_rsp_rdata;
   logic        rf_we;
   logic [3:0]  rf_dest;
   logic [31:0] rf_wdata;
   logic [3:0]  rf_dbg_src;
   logic [31:0] rf_dbg_rdata;
   logic        init_busy;
   logic        stall_req;

   int          vec = 0;
   int          miscmp = 0;
   logic [31:0] shadow [16];
   logic [31:0] exp_q [$];
   logic [31:0] exp_v;
   logic [31:0] rf_mem [16];

   always #5 clk = ~clk;

   always @(negedge clk) if (rf_we) rf_mem[rf_dest] <= rf_wdata;
   assign rf_dbg_rdata = rf_mem[rf_dbg_src];

   regfile_access_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .wb_en_in      (wb_en_in),
      .wb_dest_in    (wb_dest_in),
      .wb_value_in   (wb_value_in),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_ready (dbg_req_ready),
      .dbg_req_write (dbg_req_write),
      .dbg_req_addr  (dbg_req_addr),
      .dbg_req_wdata (dbg_req_wdata),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_ready (dbg_rsp_ready),
      .dbg_rsp_rdata (dbg_rsp_rdata),
      .rf_we         (rf_we),
      .rf_dest       (rf_dest),
      .rf_wdata      (rf_wdata),
      .rf_dbg_src    (rf_dbg_src),
      .rf_dbg_rdata  (rf_dbg_rdata),
      .init_busy     (init_busy),
      .stall_req     (stall_req)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents a request from posedge+1 and returns at posedge+1 after the accepting edge.
   task automatic issue(input logic wr, input logic [3:0] a, input logic [31:0] d);
      bit ok = 1'b0;
      dbg_req_valid = 1'b1;
      dbg_req_write = wr;
      dbg_req_addr  = a;
      dbg_req_wdata = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (dbg_req_ready) ok = 1'b1;
         tick();
      end
      dbg_req_valid = 1'b0;
      vec++;
      if (!ok) begin
         miscmp++;
         $display("FAIL req_accept: got no ready within 50 cycles, expected ready");
      end
   endtask

   task automatic sweep_checks(input string name);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         vec++;
         if ({rf_we, rf_dest, rf_wdata, init_busy} !== {1'b1, 4'(i), 32'h0, 1'b1}) begin
            miscmp++;
            $display("FAIL %s[%0d]: got we=%b dest=%0d wdata=%h busy=%b, expected we=1 dest=%0d wdata=0 busy=1",
                     name, i, rf_we, rf_dest, rf_wdata, init_busy, i);
         end
         tick();
      end
      @(negedge clk);
      vec++;
      if ({init_busy, dbg_req_ready, stall_req} !== 3'b010) begin
         miscmp++;
         $display("FAIL %s_done: got busy=%b ready=%b stall=%b, expected busy=0 ready=1 stall=0",
                  name, init_busy, dbg_req_ready, stall_req);
      end
      tick();
      for (int i = 0; i < 16; i++) shadow[i] = 32'h0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wb_en_in = 1'b0; wb_dest_in = '0; wb_value_in = '0;
      dbg_req_valid = 1'b0; dbg_req_write = 1'b0; dbg_req_addr = '0; dbg_req_wdata = '0;
      dbg_rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vec++;
      if ({init_busy, stall_req, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata} !== {4'b1000, 32'h0}) begin
         miscmp++;
         $display("FAIL reset_state: got busy=%b stall=%b ready=%b valid=%b rdata=%h, expected 1 0 0 0 00000000",
                  init_busy, stall_req, dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      // WB activity during the sweep must not reach the file.
      wb_en_in = 1'b1; wb_dest_in = 4'd15; wb_value_in = 32'hFFFF_FFFF;
      sweep_checks("init_sweep");
      wb_en_in = 1'b0;
   endtask

   task automatic test_init_read();
      exp_q.push_back(shadow[7]);
      issue(1'b0, 4'd7, 32'h0);
      @(negedge clk);
      vec++;
      if (dbg_rsp_valid !== 1'b0) begin
         miscmp++;
         $display("FAIL rd_latency_early: got valid=%b, expected 0", dbg_rsp_valid);
      end
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL init_read_r7: got valid=%b rdata=%h, expected valid=1 rdata=%h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
   endtask

   task automatic test_dbg_write();
      shadow[3] = 32'hDEAD_BEEF;
      exp_q.push_back(shadow[3]);
      issue(1'b1, 4'd3, 32'hDEAD_BEEF);
      @(negedge clk);
      vec++;
      if ({rf_we, rf_dest, rf_wdata, dbg_rsp_valid} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0}) begin
         miscmp++;
         $display("FAIL dbg_write_port: got we=%b dest=%0d wdata=%h valid=%b, expected 1 3 deadbeef 0",
                  rf_we, rf_dest, rf_wdata, dbg_rsp_valid);
      end
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL dbg_write_rsp: got valid=%b rdata=%h, expected valid=1 rdata=%h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
      exp_q.push_back(shadow[3]);
      issue(1'b0, 4'd3, 32'h0);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL readback_r3: got valid=%b rdata=%h, expected valid=1 rdata=%h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
   endtask

   task automatic test_wb_then_read();
      wb_en_in = 1'b1; wb_dest_in = 4'd5; wb_value_in = 32'h1234_5678;
      shadow[5] = 32'h1234_5678;
      tick();
      wb_en_in = 1'b0;
      exp_q.push_back(shadow[5]);
      issue(1'b0, 4'd5, 32'h0);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL wb_then_read_r5: got valid=%b rdata=%h, expected valid=1 rdata=%h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
   endtask

   task automatic test_starvation();
      wb_en_in = 1'b1; wb_dest_in = 4'd9; wb_value_in = 32'h9999_0000;
      shadow[9]  = 32'h9999_0000;
      shadow[10] = 32'hCAFE_F00D;
      exp_q.push_back(shadow[10]);
      issue(1'b1, 4'd10, 32'hCAFE_F00D);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         vec++;
         if ({stall_req, rf_we, rf_dest, rf_wdata, dbg_rsp_valid} !== {2'b01, 4'd9, 32'h9999_0000, 1'b0}) begin
            miscmp++;
            $display("FAIL starve_blocked[%0d]: got stall=%b we=%b dest=%0d wdata=%h valid=%b, expected 0 1 9 99990000 0",
                     k, stall_req, rf_we, rf_dest, rf_wdata, dbg_rsp_valid);
         end
         tick();
      end
      wb_en_in = 1'b0;
      @(negedge clk);
      vec++;
      if ({stall_req, rf_we, rf_dest, rf_wdata} !== {2'b11, 4'd10, 32'hCAFE_F00D}) begin
         miscmp++;
         $display("FAIL starve_commit: got stall=%b we=%b dest=%0d wdata=%h, expected 1 1 10 cafef00d",
                  stall_req, rf_we, rf_dest, rf_wdata);
      end
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({stall_req, dbg_rsp_valid, dbg_rsp_rdata} !== {2'b01, exp_v}) begin
         miscmp++;
         $display("FAIL starve_release: got stall=%b valid=%b rdata=%h, expected 0 1 %h",
                  stall_req, dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
   endtask

   task automatic test_backpressure();
      dbg_rsp_ready = 1'b0;
      exp_q.push_back(shadow[10]);
      issue(1'b0, 4'd10, 32'h0);
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         vec++;
         if ({dbg_rsp_valid, dbg_req_ready, dbg_rsp_rdata} !== {2'b10, exp_q[0]}) begin
            miscmp++;
            $display("FAIL rsp_hold[%0d]: got valid=%b ready=%b rdata=%h, expected 1 0 %h",
                     k, dbg_rsp_valid, dbg_req_ready, dbg_rsp_rdata, exp_q[0]);
         end
         tick();
      end
      dbg_rsp_ready = 1'b1;
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL rsp_handshake: got valid=%b rdata=%h, expected 1 %h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
      @(negedge clk);
      vec++;
      if ({dbg_rsp_valid, dbg_req_ready} !== 2'b01) begin
         miscmp++;
         $display("FAIL rsp_to_idle: got valid=%b ready=%b, expected 0 1", dbg_rsp_valid, dbg_req_ready);
      end
      tick();
   endtask

   task automatic test_reset_in_wr_wait();
      wb_en_in = 1'b1; wb_dest_in = 4'd2; wb_value_in = 32'h2222_2222;
      issue(1'b1, 4'd12, 32'hBAD0_BAD0);
      repeat (9) begin
         @(negedge clk);
         tick();
      end
      @(negedge clk);
      vec++;
      if (stall_req !== 1'b1) begin
         miscmp++;
         $display("FAIL abort_precond_stall: got stall=%b, expected 1", stall_req);
      end
      #2;
      rst = 1'b0;
      wb_en_in = 1'b0;
      #1;
      vec++;
      if ({stall_req, dbg_rsp_valid, init_busy, dbg_req_ready, rf_we, rf_dest, rf_wdata}
          !== {4'b0010, 1'b1, 4'd0, 32'h0}) begin
         miscmp++;
         $display("FAIL abort_reset: got stall=%b valid=%b busy=%b ready=%b we=%b dest=%0d wdata=%h, expected 0 0 1 0 1 0 00000000",
                  stall_req, dbg_rsp_valid, init_busy, dbg_req_ready, rf_we, rf_dest, rf_wdata);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      sweep_checks("resweep");
      exp_q.push_back(shadow[12]);
      issue(1'b0, 4'd12, 32'h0);
      tick();
      @(negedge clk);
      exp_v = exp_q.pop_front();
      vec++;
      if ({dbg_rsp_valid, dbg_rsp_rdata} !== {1'b1, exp_v}) begin
         miscmp++;
         $display("FAIL abort_r12_cleared: got valid=%b rdata=%h, expected 1 %h",
                  dbg_rsp_valid, dbg_rsp_rdata, exp_v);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_init_read();
      test_dbg_write();
      test_wb_then_read();
      test_starvation();
      test_backpressure();
      test_reset_in_wr_wait();
      vec++;
      if (exp_q.size() != 0) begin
         miscmp++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

endmodule
